fluxo_dados_multiciclo: RTL and testbench
=========================================

# fluxo_dados_multiciclo

Parametrised multi-cycle RV64I-subset datapath and control, the successor to the single-cycle add/sub dataflow. It owns the PC, instruction register, register file, immediate generation and ALU, and sequences them with an internal FSM. All instruction fetches and data accesses go through one shared memory port with a req/ack handshake. It sits between the processor top level and the memory subsystem.

## Interface
- XLEN, 64: datapath width; legal values are 32 and 64. LD/SD move XLEN bits.
- NREG, 32: register count; legal values are 16 and 32. Register indices ≥ NREG are illegal.
- RESET_PC, 0: PC value after reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- mem_req  out  1  memory request; held until acknowledged.
- mem_we  out  1  1 = store, 0 = read.
- mem_addr  out  XLEN  byte address.
- mem_wdata  out  XLEN  store data.
- mem_rdata  in  XLEN  read data; instruction is in [31:0]; sampled on the ack cycle.
- mem_ack  in  1  transaction complete; single-cycle pulse.
- pc  out  XLEN  current PC.
- halted  out  1  sticky; set on an illegal instruction.
- retire  out  1  one-cycle pulse per completed instruction.

## Operation
- Supported instructions: ADD, SUB (OP, funct7 0x00/0x20); ADDI; LD; SD; BEQ, BNE, BLT, BGEU; LUI; JAL.
- Any other opcode/funct3/funct7 combination, or a register index ≥ NREG, is illegal: the FSM enters TRAP.
- x0 always reads 0. Writes to x0 are discarded.
- Immediate formats I/S/B/U/J are sign-extended to XLEN. The U immediate is shifted left by 12.
- ALU wraps modulo 2^XLEN. Branch comparisons:
  - BLT: signed less-than.
  - BGEU: unsigned greater-or-equal.
- FSM states are FETCH, DECODE, EXEC, MEM, WB, TRAP.
- FETCH: mem_req=1, mem_we=0, mem_addr=pc. On mem_ack, IR ← mem_rdata[31:0], then go to DECODE.
- DECODE: A ← rf[rs1] and B ← rf[rs2]; immediate is latched; illegal check is done here. Next state is EXEC, or TRAP if illegal.
- EXEC: ALUOut is computed.
  - Branches: pc ← pc+imm if the condition holds, else pc+4; retire pulses; next state FETCH.
  - LD/SD: next state MEM.
  - All others: next state WB.
- MEM: mem_req=1, mem_addr=ALUOut, mem_we=1 for SD with mem_wdata=B.
  - On ack, SD: pc ← pc+4, retire pulses, next state FETCH.
  - On ack, LD: MDR ← mem_rdata, next state WB.
- WB: rd is written with ALUOut, MDR (LD), imm (LUI), or pc+4 (JAL). The PC then advances:
  - JAL: pc ← pc+imm.
  - All others: pc ← pc+4.
  - retire pulses; next state FETCH.
- TRAP: terminal state. halted=1 and mem_req=0. Exited only by rst.
- mem_addr, mem_we and mem_wdata are stable while mem_req=1.
- Misaligned addresses are passed through unchanged; alignment is the memory's responsibility.

## Timing
- Reset values: state=FETCH, pc=RESET_PC, halted=0, retire=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
- The register file is not cleared except x0.
- mem_req is registered: it asserts in the first FETCH cycle after reset deasserts.
- An ack may arrive in the same cycle mem_req first rises. Zero-wait latency per memory phase is 1 cycle.
- An ack while mem_req=0 is ignored.
- Cycles per instruction with zero-wait memory:
  - Branch: 3.
  - ADD/SUB/ADDI/LUI/JAL: 4.
  - SD: 4.
  - LD: 5.
- Each memory wait cycle adds 1 cycle.
- rst asserted mid-transaction forces the reset values immediately, with mem_req dropping asynchronously. A pending ack is lost, and the memory must tolerate the abandoned request.
- The register file writes on the rising edge at the end of WB. A read of the same register in the following DECODE sees the new value.

## Structure
- Shared package fd_pkg holds:
  - opcode constants (OP, OP_IMM, LOAD, STORE, BRANCH, LUI, JAL);
  - the state enum;
  - immediate-format enum I/S/B/U/J;
  - ALU op enum ADD/SUB/PASS_B.
- Sub-module banco_registradores_p, parametrised by XLEN and NREG:
  - 2 combinational read ports;
  - 1 synchronous write port;
  - x0 hard-wired to zero.
- Immediate generation and the ALU stay inline.

## Test plan
- Reset, then memory returns ADDI x1,x0,5 (0x00500093) with zero-wait ack → x1=5, pc=4, retire pulses once, 4 cycles after the first mem_req.
- ADDI x1,x0,-1 followed by SUB x2,x0,x1 → x2=1. With XLEN=32, ADDI x3,x1,1 → x3=0 (wrap-around).
- Run SD x2,8(x0), then LD x4,8(x0) against a model memory with 3 wait cycles. Required results:
  - mem_addr=8 and mem_wdata=1 held stable throughout the request;
  - x4=1;
  - LD takes 8 cycles.
- Run BLT x1,x2,+16 with x1=-1 and x2=1 → pc advances by 16. Run BGEU with the same operands → branch taken (0xFFFF… ≥ 1). BEQ with unequal operands → pc+4.
- JAL x5,-8 at pc=0x20 → x5=0x24, pc=0x18. ADDI x0,x0,7 → x0 still reads 0.
- Fetch of 0xFFFFFFFF → halted=1 after DECODE, mem_req stays 0. A later rst mid-FETCH returns pc=RESET_PC and halted=0.

Source files
------------

// File: rtl/fd_pkg.sv
// Shared definitions for the multi-cycle RV64I-subset datapath: opcodes, FSM states, formats.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fd_pkg;

  // Major opcodes of the supported instruction subset
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_D    = 3'b011;  // LD / SD doubleword
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [6:0] F7_ADD = 7'h00;
  localparam logic [6:0] F7_SUB = 7'h20;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;
  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_t;
  typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_PASS_B} alu_op_t;

  function automatic imm_fmt_t imm_fmt(input logic [6:0] opc);
    case (opc)
      OPC_STORE:  return IMM_S;
      OPC_BRANCH: return IMM_B;
      OPC_LUI:    return IMM_U;
      OPC_JAL:    return IMM_J;
      default:    return IMM_I;
    endcase
  endfunction

  // 32-bit signed immediate; the caller sign-extends it to XLEN with a size cast.
  function automatic logic signed [31:0] imm32(input logic [31:0] ir, input imm_fmt_t fmt);
    case (fmt)
      IMM_S:   return {{20{ir[31]}}, ir[31:25], ir[11:7]};
      IMM_B:   return {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      IMM_U:   return {ir[31:12], 12'b0};
      IMM_J:   return {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      default: return {{20{ir[31]}}, ir[31:20]};
    endcase
  endfunction

endpackage

// File: rtl/fluxo_dados_multiciclo_if.sv
// Shared memory port (req/ack) between the multi-cycle datapath and the memory subsystem.
// Latency: n/a (wiring only).
// Backpressure: master holds req/addr/we/wdata stable until a one-cycle ack.
// Ports: mem_req/mem_we/mem_addr/mem_wdata driven by master; mem_rdata/mem_ack driven by slave.
interface fluxo_dados_multiciclo_if #(
  parameter int XLEN = 64
);
  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [XLEN-1:0] mem_rdata;
  logic            mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/banco_registradores_p.sv
// Register file: 2 combinational read ports, 1 synchronous write port, x0 hard-wired to zero.
// Latency: reads 0 cycles; write visible after the clock edge that performs it.
// Backpressure: none (always accepts).
// Ports: i_clk; i_we/i_waddr/i_wdata write port; i_raddr1/2 -> o_rdata1/2 read ports.
module banco_registradores_p #(
  parameter int XLEN = 64,
  parameter int NREG = 32
) (
  input  logic                    i_clk,
  input  logic                    i_we,
  input  logic [$clog2(NREG)-1:0] i_waddr,
  input  logic [XLEN-1:0]         i_wdata,
  input  logic [$clog2(NREG)-1:0] i_raddr1,
  input  logic [$clog2(NREG)-1:0] i_raddr2,
  output logic [XLEN-1:0]         o_rdata1,
  output logic [XLEN-1:0]         o_rdata2
);
  // Contents are deliberately not reset; only x0 has a defined value.
  logic [XLEN-1:0] r_regs [NREG];

  always_ff @(posedge i_clk) begin
    if (i_we && (i_waddr != '0)) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata1 = (i_raddr1 == '0) ? '0 : r_regs[i_raddr1];
  assign o_rdata2 = (i_raddr2 == '0) ? '0 : r_regs[i_raddr2];
endmodule

// File: rtl/fluxo_dados_multiciclo.sv
// Multi-cycle RV64I-subset datapath + control (FETCH/DECODE/EXEC/MEM/WB/TRAP) on one memory port.
// Latency: zero-wait CPI branch 3, ALU/LUI/JAL/SD 4, LD 5; each memory wait cycle adds 1.
// Backpressure: FETCH/MEM stall with mem_req held and stable until mem_ack; TRAP is terminal.
// Ports: clk, rst (async, active-high); mem (master modport); pc, halted (sticky), retire (pulse).
module fluxo_dados_multiciclo
  import fd_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter int              NREG     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  fluxo_dados_multiciclo_if.master  mem,
  output logic [XLEN-1:0]           pc,
  output logic                      halted,
  output logic                      retire
);
  localparam int AW = $clog2(NREG);

  state_t          r_state, w_next;
  logic [XLEN-1:0] r_pc, w_pc_next;
  logic [31:0]     r_ir;
  logic [XLEN-1:0] r_a, r_b, r_imm, r_alu, r_mdr;
  logic            r_mem_req, r_mem_we;
  logic [XLEN-1:0] r_mem_addr, r_mem_wdata;

  logic [6:0]      w_opc, w_f7;
  logic [2:0]      w_f3;
  logic [4:0]      w_rd, w_rs1, w_rs2;
  logic [XLEN-1:0] w_imm, w_rs1_val, w_rs2_val, w_alu_b, w_alu, w_pc4, w_pc_imm, w_rf_wdata;
  alu_op_t         w_alu_op;
  logic            w_legal, w_take, w_ack, w_retire, w_rf_we;

  function automatic logic reg_ok(input logic [4:0] idx);
    return int'(idx) < NREG;
  endfunction

  // Instruction fields are decoded from IR, which stays stable from DECODE to the end of the instruction.
  assign w_opc = r_ir[6:0];
  assign w_rd  = r_ir[11:7];
  assign w_f3  = r_ir[14:12];
  assign w_rs1 = r_ir[19:15];
  assign w_rs2 = r_ir[24:20];
  assign w_f7  = r_ir[31:25];
  assign w_imm = XLEN'(imm32(r_ir, imm_fmt(w_opc)));

  // An ack is only meaningful while we are actually requesting.
  assign w_ack = mem.mem_ack && r_mem_req;

  banco_registradores_p #(.XLEN(XLEN), .NREG(NREG)) u_rf (
    .i_clk    (clk),
    .i_we     (w_rf_we),
    .i_waddr  (w_rd[AW-1:0]),
    .i_wdata  (w_rf_wdata),
    .i_raddr1 (w_rs1[AW-1:0]),
    .i_raddr2 (w_rs2[AW-1:0]),
    .o_rdata1 (w_rs1_val),
    .o_rdata2 (w_rs2_val)
  );

  always_comb begin
    w_legal = 1'b0;
    case (w_opc)
      OPC_OP:     w_legal = (w_f3 == F3_ADD) && ((w_f7 == F7_ADD) || (w_f7 == F7_SUB)) &&
                            reg_ok(w_rd) && reg_ok(w_rs1) && reg_ok(w_rs2);
      OPC_OP_IMM: w_legal = (w_f3 == F3_ADD) && reg_ok(w_rd) && reg_ok(w_rs1);
      OPC_LOAD:   w_legal = (w_f3 == F3_D) && reg_ok(w_rd) && reg_ok(w_rs1);
      OPC_STORE:  w_legal = (w_f3 == F3_D) && reg_ok(w_rs1) && reg_ok(w_rs2);
      OPC_BRANCH: w_legal = ((w_f3 == F3_BEQ) || (w_f3 == F3_BNE) || (w_f3 == F3_BLT) ||
                             (w_f3 == F3_BGEU)) && reg_ok(w_rs1) && reg_ok(w_rs2);
      OPC_LUI:    w_legal = reg_ok(w_rd);
      OPC_JAL:    w_legal = reg_ok(w_rd);
      default:    w_legal = 1'b0;
    endcase
  end

  // ALU: register-register for OP, otherwise the latched immediate (address calc, ADDI, LUI).
  always_comb begin
    w_alu_op = ALU_ADD;
    if ((w_opc == OPC_OP) && (w_f7 == F7_SUB)) w_alu_op = ALU_SUB;
    else if (w_opc == OPC_LUI)                  w_alu_op = ALU_PASS_B;
  end

  assign w_alu_b = (w_opc == OPC_OP) ? r_b : r_imm;

  always_comb begin
    case (w_alu_op)
      ALU_SUB:    w_alu = r_a - w_alu_b;
      ALU_PASS_B: w_alu = w_alu_b;
      default:    w_alu = r_a + w_alu_b;
    endcase
  end

  always_comb begin
    case (w_f3)
      F3_BEQ:  w_take = (r_a == r_b);
      F3_BNE:  w_take = (r_a != r_b);
      F3_BLT:  w_take = ($signed(r_a) < $signed(r_b));
      F3_BGEU: w_take = (r_a >= r_b);
      default: w_take = 1'b0;
    endcase
  end

  assign w_pc4    = r_pc + XLEN'(4);
  assign w_pc_imm = r_pc + r_imm;

  always_comb begin
    w_next     = r_state;
    w_pc_next  = r_pc;
    w_retire   = 1'b0;
    w_rf_we    = 1'b0;
    w_rf_wdata = r_alu;
    case (r_state)
      FETCH:  if (w_ack) w_next = DECODE;
      DECODE: w_next = w_legal ? EXEC : TRAP;
      EXEC: begin
        if (w_opc == OPC_BRANCH) begin
          w_pc_next = w_take ? w_pc_imm : w_pc4;
          w_retire  = 1'b1;
          w_next    = FETCH;
        end else if ((w_opc == OPC_LOAD) || (w_opc == OPC_STORE)) begin
          w_next = MEM;
        end else begin
          w_next = WB;
        end
      end
      MEM: begin
        if (w_ack) begin
          if (w_opc == OPC_STORE) begin
            w_pc_next = w_pc4;
            w_retire  = 1'b1;
            w_next    = FETCH;
          end else begin
            w_next = WB;
          end
        end
      end
      WB: begin
        w_rf_we = 1'b1;
        case (w_opc)
          OPC_LOAD: w_rf_wdata = r_mdr;
          OPC_LUI:  w_rf_wdata = r_imm;
          OPC_JAL:  w_rf_wdata = w_pc4;
          default:  w_rf_wdata = r_alu;
        endcase
        w_pc_next = (w_opc == OPC_JAL) ? w_pc_imm : w_pc4;
        w_retire  = 1'b1;
        w_next    = FETCH;
      end
      TRAP:    w_next = TRAP;
      default: w_next = TRAP;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= FETCH;
      r_pc        <= RESET_PC;
      r_ir        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_imm       <= '0;
      r_alu       <= '0;
      r_mdr       <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_state <= w_next;
      r_pc    <= w_pc_next;
      if ((r_state == FETCH) && w_ack) r_ir <= mem.mem_rdata[31:0];
      if (r_state == DECODE) begin
        r_a   <= w_rs1_val;
        r_b   <= w_rs2_val;
        r_imm <= w_imm;
      end
      if (r_state == EXEC) r_alu <= w_alu;
      if ((r_state == MEM) && w_ack) r_mdr <= mem.mem_rdata;
      // Memory outputs are registered from the next state, so they are stable for the whole
      // request; the first cycle after reset is a FETCH with mem_req still low.
      case (w_next)
        FETCH: begin
          r_mem_req  <= 1'b1;
          r_mem_we   <= 1'b0;
          r_mem_addr <= w_pc_next;
        end
        MEM: begin
          r_mem_req   <= 1'b1;
          r_mem_we    <= (w_opc == OPC_STORE);
          r_mem_addr  <= (r_state == EXEC) ? w_alu : r_alu;
          r_mem_wdata <= r_b;
        end
        default: begin
          r_mem_req <= 1'b0;
          r_mem_we  <= 1'b0;
        end
      endcase
    end
  end

  assign mem.mem_req   = r_mem_req;
  assign mem.mem_we    = r_mem_we;
  assign mem.mem_addr  = r_mem_addr;
  assign mem.mem_wdata = r_mem_wdata;
  assign pc            = r_pc;
  assign halted        = (r_state == TRAP);
  assign retire        = w_retire;
endmodule

// File: tb/tb_fluxo_dados_multiciclo.sv
// Bench for fluxo_dados_multiciclo: directed instruction stream served by a model memory.
// Expected data accesses are queued when each instruction is issued and popped when the DUT requests.
module tb_fluxo_dados_multiciclo;
  localparam int XLEN = 64;
  localparam logic [6:0] OP = 7'b0110011, OPI = 7'b0010011, LOAD = 7'b0000011, LUI = 7'b0110111;

  logic clk = 1'b0;
  logic rst;
  logic [XLEN-1:0] pc;
  logic halted, retire;

  always #5 clk = ~clk;

  fluxo_dados_multiciclo_if #(.XLEN(XLEN)) mem_if ();

  fluxo_dados_multiciclo #(.XLEN(XLEN), .NREG(32), .RESET_PC('0)) dut (
    .clk    (clk),
    .rst    (rst),
    .mem    (mem_if),
    .pc     (pc),
    .halted (halted),
    .retire (retire)
  );

  typedef struct packed {
    logic        we;
    logic [63:0] addr;
    logic [63:0] data;
  } acc_t;

  acc_t        exp_q [$];
  logic [63:0] dmem [bit [63:0]];
  logic [63:0] exp_pc;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, 3'b000, rd, OP};
  endfunction
  function automatic logic [31:0] enc_i(input int imm, input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] op);
    logic [11:0] i;
    i = imm[11:0];
    return {i, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_s(input int imm, input logic [4:0] rs2, input logic [4:0] rs1);
    logic [11:0] i;
    i = imm[11:0];
    return {i[11:5], rs2, rs1, 3'b011, i[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_b(input int imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3);
    logic [12:0] i;
    i = imm[12:0];
    return {i[12], i[10:5], rs2, rs1, f3, i[4:1], i[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_j(input int imm, input logic [4:0] rd);
    logic [20:0] i;
    i = imm[20:0];
    return {i[20], i[10:1], i[11], i[19:12], rd, 7'b1101111};
  endfunction

  task automatic wait_req(input string tag, output bit got);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (mem_if.mem_req) got = 1'b1;
    end
    chk($sformatf("%s/fetch-req", tag), 64'(got), 64'd1);
  endtask

  // Serve one fetch (zero-wait), then any data phase with dwait wait cycles; check CPI and next pc.
  task automatic run_instr(input string tag, input logic [31:0] ins, input int dwait,
                           input logic [63:0] next_pc, input int exp_cyc);
    bit   got, done;
    int   cyc, w;
    acc_t a;
    wait_req(tag, got);
    if (!got) return;
    chk($sformatf("%s/fetch-addr", tag), mem_if.mem_addr, exp_pc);
    chk($sformatf("%s/fetch-we", tag), 64'(mem_if.mem_we), 64'd0);
    mem_if.mem_rdata = {32'h0, ins};
    mem_if.mem_ack   = 1'b1;
    cyc = 1; w = 0; done = 1'b0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      mem_if.mem_ack = 1'b0;
      cyc++;
      if (mem_if.mem_req) begin
        if (exp_q.size() == 0) begin
          chk($sformatf("%s/unexpected-req", tag), 64'(mem_if.mem_req), 64'd0);
        end else begin
          a = exp_q[0];
          chk($sformatf("%s/data-addr", tag), mem_if.mem_addr, a.addr);
          chk($sformatf("%s/data-we", tag), 64'(mem_if.mem_we), 64'(a.we));
          if (a.we) chk($sformatf("%s/data-wdata", tag), mem_if.mem_wdata, a.data);
          if (w == dwait) begin
            if (a.we) dmem[a.addr] = mem_if.mem_wdata;
            else      mem_if.mem_rdata = dmem[a.addr];
            mem_if.mem_ack = 1'b1;
            void'(exp_q.pop_front());
          end else begin
            w++;
          end
        end
      end
      #1;
      if (retire) done = 1'b1;
    end
    chk($sformatf("%s/cycles", tag), 64'(cyc), 64'(exp_cyc));
    chk($sformatf("%s/queue-drained", tag), 64'(exp_q.size()), 64'd0);
    #5;  // one time unit after the rising edge that ends the instruction
    chk($sformatf("%s/pc", tag), pc, next_pc);
    chk($sformatf("%s/retire-pulse", tag), 64'(retire), 64'd0);
    exp_pc = next_pc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    mem_if.mem_ack   = 1'b0;
    mem_if.mem_rdata = '0;
    rst    = 1'b1;
    exp_pc = 64'h0;
    repeat (2) @(negedge clk);
    chk("reset/pc", pc, 64'h0);
    chk("reset/halted", 64'(halted), 64'd0);
    chk("reset/retire", 64'(retire), 64'd0);
    chk("reset/mem_req", 64'(mem_if.mem_req), 64'd0);
    chk("reset/mem_we", 64'(mem_if.mem_we), 64'd0);
    chk("reset/mem_addr", mem_if.mem_addr, 64'h0);
    chk("reset/mem_wdata", mem_if.mem_wdata, 64'h0);
    rst = 1'b0;
    #1;
    chk("reset/req-not-yet", 64'(mem_if.mem_req), 64'd0);

    run_instr("addi_x1_5", 32'h00500093, 0, 64'h4, 4);
    exp_q.push_back('{1'b1, 64'h0, 64'd5});
    run_instr("sd_x1", enc_s(0, 1, 0), 0, 64'h8, 4);
    run_instr("addi_x1_m1", enc_i(-1, 0, 3'b000, 1, OPI), 0, 64'hC, 4);
    run_instr("sub_x2", enc_r(7'h20, 1, 0, 2), 0, 64'h10, 4);
    run_instr("addi_x3_wrap", enc_i(1, 1, 3'b000, 3, OPI), 0, 64'h14, 4);
    exp_q.push_back('{1'b1, 64'h28, 64'd0});
    run_instr("sd_x3", enc_s(32'h28, 3, 0), 0, 64'h18, 4);
    exp_q.push_back('{1'b1, 64'h8, 64'd1});
    run_instr("sd_x2_wait", enc_s(8, 2, 0), 3, 64'h1C, 7);
    exp_q.push_back('{1'b0, 64'h8, 64'd0});
    run_instr("ld_x4_wait", enc_i(8, 0, 3'b011, 4, LOAD), 3, 64'h20, 8);
    exp_q.push_back('{1'b1, 64'h30, 64'd1});
    run_instr("sd_x4", enc_s(32'h30, 4, 0), 0, 64'h24, 4);
    run_instr("blt_taken", enc_b(16, 2, 1, 3'b100), 0, 64'h34, 3);
    run_instr("bgeu_taken", enc_b(16, 2, 1, 3'b111), 0, 64'h44, 3);
    run_instr("beq_not", enc_b(16, 2, 1, 3'b000), 0, 64'h48, 3);
    run_instr("bne_taken", enc_b(-40, 2, 1, 3'b001), 0, 64'h20, 3);
    run_instr("jal_x5", enc_j(-8, 5), 0, 64'h18, 4);
    exp_q.push_back('{1'b1, 64'h38, 64'h24});
    run_instr("sd_x5", enc_s(32'h38, 5, 0), 0, 64'h1C, 4);
    run_instr("addi_x0", enc_i(7, 0, 3'b000, 0, OPI), 0, 64'h20, 4);
    exp_q.push_back('{1'b1, 64'h40, 64'd0});
    run_instr("sd_x0", enc_s(32'h40, 0, 0), 0, 64'h24, 4);
    run_instr("add_x7", enc_r(7'h00, 2, 2, 7), 0, 64'h28, 4);
    exp_q.push_back('{1'b1, 64'h60, 64'd2});
    run_instr("sd_x7", enc_s(32'h60, 7, 0), 0, 64'h2C, 4);
    run_instr("lui_x6", {20'h80000, 5'd6, LUI}, 0, 64'h30, 4);
    exp_q.push_back('{1'b1, 64'h48, 64'hFFFF_FFFF_8000_0000});
    run_instr("sd_x6", enc_s(32'h48, 6, 0), 0, 64'h34, 4);

    // Illegal instruction: TRAP after DECODE, port silent, stray acks ignored
    wait_req("trap", got);
    chk("trap/fetch-addr", mem_if.mem_addr, exp_pc);
    mem_if.mem_rdata = 64'hFFFF_FFFF;
    mem_if.mem_ack   = 1'b1;
    @(negedge clk);
    mem_if.mem_ack = 1'b0;
    chk("trap/decode-halted", 64'(halted), 64'd0);
    @(negedge clk);
    chk("trap/halted", 64'(halted), 64'd1);
    chk("trap/mem_req", 64'(mem_if.mem_req), 64'd0);
    mem_if.mem_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      mem_if.mem_ack = 1'b0;
      chk("trap/hold-req", 64'(mem_if.mem_req), 64'd0);
      chk("trap/hold-retire", 64'(retire), 64'd0);
      chk("trap/hold-halted", 64'(halted), 64'd1);
    end

    rst = 1'b1;
    #1;
    chk("trap-rst/halted", 64'(halted), 64'd0);
    chk("trap-rst/pc", pc, 64'h0);
    @(negedge clk);
    rst    = 1'b0;
    exp_pc = 64'h0;
    run_instr("addi_x8", enc_i(9, 0, 3'b000, 8, OPI), 0, 64'h4, 4);

    // Reset while a fetch is outstanding: request must drop without waiting for a clock
    @(negedge clk);
    chk("midfetch/req-pending", 64'(mem_if.mem_req), 64'd1);
    rst = 1'b1;
    #1;
    chk("midfetch/mem_req", 64'(mem_if.mem_req), 64'd0);
    chk("midfetch/pc", pc, 64'h0);
    chk("midfetch/mem_addr", mem_if.mem_addr, 64'h0);
    chk("midfetch/halted", 64'(halted), 64'd0);
    @(negedge clk);
    rst    = 1'b0;
    exp_pc = 64'h0;
    // Register file survives reset: x1 still holds -1
    exp_q.push_back('{1'b1, 64'h50, 64'hFFFF_FFFF_FFFF_FFFF});
    run_instr("sd_x1_after_rst", enc_s(32'h50, 1, 0), 0, 64'h4, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
